// File: rtl/sys_bus_arbiter.sv
// sys_bus_arbiter: two-master arbiter and transaction sequencer for the system bus.
// Optional macro SYS_BUS_ARB_FIXED_PRIORITY_EN: master 0 always wins a tie.
//
// Ports:
//   clk, rst                  rising-edge clock, asynchronous active-high reset
//   m0_* / m1_*               master request sets (req, addr, read_type,
//                             device_id, write_data, write_en) and their
//                             completion outputs (ack pulse, read_data)
//   bus_addr .. bus_write_en  shared system bus request, driven only in ACCESS
//   bus_read_data             read data returned by the system bus
//   busy                      high while a transaction is in flight
//
// Parameters:
//   MEM_LATENCY  cycles the bus is driven before read data is sampled (1..15)
//   ADDR_W       address width
//   DATA_W       data width

module sys_bus_arbiter #(
    parameter int MEM_LATENCY = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [2:0]        m0_read_type,
    input  logic              m0_device_id,
    input  logic [DATA_W-1:0] m0_write_data,
    input  logic              m0_write_en,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_read_data,

    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [2:0]        m1_read_type,
    input  logic              m1_device_id,
    input  logic [DATA_W-1:0] m1_write_data,
    input  logic              m1_write_en,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_read_data,

    output logic [ADDR_W-1:0] bus_addr,
    output logic [2:0]        bus_read_type,
    output logic              bus_device_id,
    output logic [DATA_W-1:0] bus_write_data,
    output logic              bus_write_en,
    input  logic [DATA_W-1:0] bus_read_data,

    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(MEM_LATENCY - 1);

    state_t            state_q, state_d;
    logic              gnt_q, gnt_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        rtype_q, rtype_d;
    logic              dev_q, dev_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] rd0_q, rd0_d;
    logic [DATA_W-1:0] rd1_q, rd1_d;

    logic any_req;
    logic pick;
    logic grant;

    assign any_req = m0_req | m1_req;
    assign grant   = (state_q == IDLE) & any_req;

    // pick selects the master granted when any request is pending:
    // 0 = master 0, 1 = master 1.
`ifdef SYS_BUS_ARB_FIXED_PRIORITY_EN
    assign pick = ~m0_req;
`else
    logic last_q, last_d;

    // On a tie the master that did not win last time goes next.
    assign pick   = (m0_req & m1_req) ? ~last_q : m1_req;
    assign last_d = grant ? pick : last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    always_comb begin
        state_d        = state_q;
        gnt_d          = gnt_q;
        cnt_d          = cnt_q;
        addr_d         = addr_q;
        rtype_d        = rtype_q;
        dev_d          = dev_q;
        wdata_d        = wdata_q;
        we_d           = we_q;
        rd0_d          = rd0_q;
        rd1_d          = rd1_q;
        bus_addr       = '0;
        bus_read_type  = '0;
        bus_device_id  = 1'b0;
        bus_write_data = '0;
        bus_write_en   = 1'b0;
        m0_ack         = 1'b0;
        m1_ack         = 1'b0;
        busy           = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = ACCESS;
                    gnt_d   = pick;
                    cnt_d   = '0;
                    addr_d  = pick ? m1_addr : m0_addr;
                    rtype_d = pick ? m1_read_type : m0_read_type;
                    dev_d   = pick ? m1_device_id : m0_device_id;
                    wdata_d = pick ? m1_write_data : m0_write_data;
                    we_d    = pick ? m1_write_en : m0_write_en;
                end
            end

            ACCESS: begin
                busy           = 1'b1;
                bus_addr       = addr_q;
                bus_read_type  = rtype_q;
                bus_device_id  = dev_q;
                bus_write_data = wdata_q;
                // Single store strobe: only the first ACCESS cycle.
                bus_write_en   = we_q & (cnt_q == 4'd0);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    if (!we_q) begin
                        if (gnt_q) begin
                            rd1_d = bus_read_data;
                        end else begin
                            rd0_d = bus_read_data;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            DONE: begin
                busy    = 1'b1;
                m0_ack  = ~gnt_q;
                m1_ack  = gnt_q;
                cnt_d   = '0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= '0;
            rtype_q <= '0;
            dev_q   <= 1'b0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rd0_q   <= '0;
            rd1_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rtype_q <= rtype_d;
            dev_q   <= dev_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
        end
    end

    assign m0_read_data = rd0_q;
    assign m1_read_data = rd1_q;

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// tb_sys_bus_arbiter: randomized and directed bench for sys_bus_arbiter.
// A transaction-level model queues expected responses; a monitor checks them.

module tb_sys_bus_arbiter;

    localparam int L = 2;

    logic        clk;
    logic        rst;

    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m1_addr;
    logic [2:0]  m0_read_type, m1_read_type;
    logic        m0_device_id, m1_device_id;
    logic [31:0] m0_write_data, m1_write_data;
    logic        m0_write_en, m1_write_en;
    logic        m0_ack, m1_ack;
    logic [31:0] m0_read_data, m1_read_data;
    logic [31:0] bus_addr;
    logic [2:0]  bus_read_type;
    logic        bus_device_id;
    logic [31:0] bus_write_data;
    logic        bus_write_en;
    logic [31:0] bus_read_data;
    logic        busy;

    logic        d1_m0_req, d1_m1_req;
    logic [31:0] d1_m0_addr, d1_m1_addr;
    logic        d1_m0_ack, d1_m1_ack;
    logic [31:0] d1_m0_read_data, d1_m1_read_data;
    logic [31:0] d1_bus_addr;
    logic [2:0]  d1_bus_read_type;
    logic        d1_bus_device_id;
    logic [31:0] d1_bus_write_data;
    logic        d1_bus_write_en;
    logic [31:0] d1_bus_read_data;
    logic        d1_busy;

    sys_bus_arbiter #(.MEM_LATENCY(L), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_read_type(m0_read_type),
        .m0_device_id(m0_device_id), .m0_write_data(m0_write_data),
        .m0_write_en(m0_write_en), .m0_ack(m0_ack), .m0_read_data(m0_read_data),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_read_type(m1_read_type),
        .m1_device_id(m1_device_id), .m1_write_data(m1_write_data),
        .m1_write_en(m1_write_en), .m1_ack(m1_ack), .m1_read_data(m1_read_data),
        .bus_addr(bus_addr), .bus_read_type(bus_read_type),
        .bus_device_id(bus_device_id), .bus_write_data(bus_write_data),
        .bus_write_en(bus_write_en), .bus_read_data(bus_read_data),
        .busy(busy)
    );

    sys_bus_arbiter #(.MEM_LATENCY(1), .ADDR_W(32), .DATA_W(32)) dut1 (
        .clk(clk), .rst(rst),
        .m0_req(d1_m0_req), .m0_addr(d1_m0_addr), .m0_read_type(3'd2),
        .m0_device_id(1'b0), .m0_write_data(32'd0),
        .m0_write_en(1'b0), .m0_ack(d1_m0_ack), .m0_read_data(d1_m0_read_data),
        .m1_req(d1_m1_req), .m1_addr(d1_m1_addr), .m1_read_type(3'd0),
        .m1_device_id(1'b0), .m1_write_data(32'd0),
        .m1_write_en(1'b0), .m1_ack(d1_m1_ack), .m1_read_data(d1_m1_read_data),
        .bus_addr(d1_bus_addr), .bus_read_type(d1_bus_read_type),
        .bus_device_id(d1_bus_device_id), .bus_write_data(d1_bus_write_data),
        .bus_write_en(d1_bus_write_en), .bus_read_data(d1_bus_read_data),
        .busy(d1_busy)
    );

    typedef struct {
        int          m;
        int          g;
        logic [31:0] addr;
        logic [2:0]  rt;
        logic        dev;
        logic [31:0] wd;
        logic        we;
        logic [31:0] rd;
    } txn_t;

    txn_t        q[$];
    int          ack_log[$];
    logic [31:0] rdv [4096];
    logic [31:0] sh [2];
    int          e = 0;
    int          free_at = 0;
    int          last = 1;
    int          errors = 0;
    int          checks = 0;
    int          wecnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [159:0] act,
                       input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Read data presented by the bus: a fresh value every cycle.
    initial begin
        bus_read_data = '0;
        forever begin
            @(posedge clk);
            #1 bus_read_data = rdv[e % 4096];
        end
    end

    // Reference model: arbitration decided per transaction, not per state.
    initial begin
        txn_t t;
        int   m;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                q.delete();
                free_at = 0;
                last    = 1;
                sh[0]   = '0;
                sh[1]   = '0;
            end else begin
                e++;
                if (e >= free_at && (m0_req || m1_req)) begin
`ifdef SYS_BUS_ARB_FIXED_PRIORITY_EN
                    m = m0_req ? 0 : 1;
`else
                    if (m0_req && m1_req) m = 1 - last;
                    else m = m0_req ? 0 : 1;
`endif
                    last = m;
                    t.m  = m;
                    t.g  = e;
                    if (m == 0) begin
                        t.addr = m0_addr; t.rt = m0_read_type;
                        t.dev  = m0_device_id; t.wd = m0_write_data;
                        t.we   = m0_write_en;
                    end else begin
                        t.addr = m1_addr; t.rt = m1_read_type;
                        t.dev  = m1_device_id; t.wd = m1_write_data;
                        t.we   = m1_write_en;
                    end
                    t.rd = rdv[(e + L - 1) % 4096];
                    q.push_back(t);
                    free_at = e + L + 2;
                end
            end
        end
    end

    // Monitor: compares DUT outputs each cycle against the queue head.
    initial begin
        logic [31:0] ea, ewd;
        logic [2:0]  ert;
        logic        edev, ewe, eb, ea0, ea1, done;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("reset_idle",
                    {bus_addr, bus_read_type, bus_device_id, bus_write_data,
                     bus_write_en, busy, m0_ack, m1_ack,
                     m0_read_data, m1_read_data}, '0);
            end else begin
                ea = '0; ewd = '0; ert = '0; edev = 0; ewe = 0;
                eb = 0; ea0 = 0; ea1 = 0; done = 0;
                if (q.size() > 0 && e >= q[0].g && e < q[0].g + L) begin
                    ea = q[0].addr; ert = q[0].rt; edev = q[0].dev;
                    ewd = q[0].wd; ewe = q[0].we && (e == q[0].g);
                    eb = 1;
                end else if (q.size() > 0 && e == q[0].g + L) begin
                    eb = 1;
                    ea0 = (q[0].m == 0);
                    ea1 = (q[0].m == 1);
                    if (!q[0].we) sh[q[0].m] = q[0].rd;
                    done = 1;
                end
                chk("bus",
                    {bus_addr, bus_read_type, bus_device_id, bus_write_data,
                     bus_write_en, busy, m0_ack, m1_ack},
                    {ea, ert, edev, ewd, ewe, eb, ea0, ea1});
                chk("rdata", {m0_read_data, m1_read_data}, {sh[0], sh[1]});
                if (done) void'(q.pop_front());
            end
        end
    end

    task automatic rand_m(input int m);
        if (m == 0) begin
            m0_addr = $urandom; m0_read_type = 3'($urandom_range(0, 7));
            m0_device_id = 1'($urandom_range(0, 1));
            m0_write_data = $urandom;
            m0_write_en = 1'($urandom_range(0, 1)); m0_req = 1'b1;
        end else begin
            m1_addr = $urandom; m1_read_type = 3'($urandom_range(0, 7));
            m1_device_id = 1'($urandom_range(0, 1));
            m1_write_data = $urandom;
            m1_write_en = 1'($urandom_range(0, 1)); m1_req = 1'b1;
        end
    endtask

    task automatic set_m(input int m, input logic [31:0] a,
                         input logic [2:0] rt, input logic dv,
                         input logic [31:0] wd, input logic we);
        if (m == 0) begin
            m0_addr = a; m0_read_type = rt; m0_device_id = dv;
            m0_write_data = wd; m0_write_en = we; m0_req = 1'b1;
        end else begin
            m1_addr = a; m1_read_type = rt; m1_device_id = dv;
            m1_write_data = wd; m1_write_en = we; m1_req = 1'b1;
        end
    endtask

    // One cycle of master behaviour; returns #1 after the next rising edge.
    task automatic step(input bit allow, input bit hold);
        logic a0, a1;
        @(negedge clk);
        a0 = m0_ack;
        a1 = m1_ack;
        if (bus_write_en) wecnt++;
        if (a0) ack_log.push_back(0);
        if (a1) ack_log.push_back(1);
        @(posedge clk);
        #1;
        if (a0 && !hold) m0_req = 1'b0;
        else if (allow && !m0_req && $urandom_range(0, 99) < 40) rand_m(0);
        if (a1 && !hold) m1_req = 1'b0;
        else if (allow && !m1_req && $urandom_range(0, 99) < 40) rand_m(1);
    endtask

    initial begin
        int n;
        int exp_order [4];
`ifdef SYS_BUS_ARB_FIXED_PRIORITY_EN
        exp_order = '{0, 0, 0, 0};
`else
        exp_order = '{0, 1, 0, 1};
`endif
        for (int i = 0; i < 4096; i++)
            rdv[i] = (i < 40) ? 32'hDEADBEEF : $urandom;
        rst = 1'b1;
        m0_req = 0; m0_addr = 0; m0_read_type = 0; m0_device_id = 0;
        m0_write_data = 0; m0_write_en = 0;
        m1_req = 0; m1_addr = 0; m1_read_type = 0; m1_device_id = 0;
        m1_write_data = 0; m1_write_en = 0;
        d1_m0_req = 0; d1_m0_addr = 0; d1_m1_req = 0; d1_m1_addr = 0;
        d1_bus_read_data = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {bus_addr, bus_write_en, busy, m0_ack, m1_ack,
                            m0_read_data, m1_read_data, d1_busy}, '0);
        @(posedge clk);
        #1 rst = 1'b0;

        repeat (2) step(0, 0);
        ack_log.delete();
        set_m(0, 32'h100, 3'b010, 1'b0, 32'h0, 1'b0);
        repeat (10) step(0, 0);
        chk("single_acks", ack_log.size(), 1);
        chk("single_rdata", m0_read_data, 32'hDEADBEEF);

        ack_log.delete();
        wecnt = 0;
        set_m(1, 32'h8000_0004, 3'b010, 1'b1, 32'h55, 1'b1);
        repeat (10) step(0, 0);
        chk("wr_strobe_cycles", wecnt, 1);
        chk("wr_acks", ack_log.size(), 1);
        chk("wr_m1_rdata", m1_read_data, 32'h0);

        set_m(0, 32'h1000, 3'b010, 1'b0, 32'h0, 1'b0);
        set_m(1, 32'h2000, 3'b010, 1'b0, 32'h0, 1'b0);
        ack_log.delete();
        n = 0;
        while (ack_log.size() < 4 && n < 60) begin
            step(0, 1);
            n++;
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        chk("cont_count", ack_log.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("cont_order", (i < ack_log.size()) ? ack_log[i] : 9,
                exp_order[i]);

        repeat (3) step(0, 0);
        ack_log.delete();
        set_m(0, 32'h3000, 3'b000, 1'b0, 32'h0, 1'b0);
        repeat (8) step(0, 1);
        m0_req = 1'b0;
        chk("held_acks", ack_log.size(), 2);

        repeat (3) step(0, 0);
        set_m(0, 32'h200, 3'b010, 1'b0, 32'hABCD, 1'b1);
        step(0, 1);
        chk("rst_pre_we", bus_write_en, 1'b1);
        set_m(1, 32'h300, 3'b010, 1'b0, 32'h0, 1'b0);
        rst = 1'b1;
        #1;
        chk("rst_cut", {bus_write_en, busy, m0_ack, m1_ack, bus_addr}, '0);
        step(0, 1);
        step(0, 1);
        rst = 1'b0;
        ack_log.delete();
        n = 0;
        while (ack_log.size() < 2 && n < 30) begin
            step(0, 0);
            n++;
        end
        chk("rst_first_grant", (ack_log.size() > 0) ? ack_log[0] : 9, 0);
        chk("rst_second_grant", (ack_log.size() > 1) ? ack_log[1] : 9, 1);

        repeat (600) step(1, $urandom_range(0, 9) == 0);
        repeat (20) step(0, 0);
        chk("drain_idle", {busy, m0_req, m1_req}, 3'b000);

        d1_bus_read_data = 32'h1111_1111;
        d1_m0_addr = 32'h40;
        d1_m0_req = 1'b1;
        @(negedge clk);
        chk("l1_pre", {d1_m0_ack, d1_busy}, 2'b00);
        @(posedge clk);
        #1 d1_bus_read_data = 32'hCAFE_F00D;
        @(negedge clk);
        chk("l1_access", {d1_bus_addr, d1_busy, d1_m0_ack},
            {32'h40, 1'b1, 1'b0});
        @(posedge clk);
        #1;
        d1_bus_read_data = 32'h2222_2222;
        d1_m0_req = 1'b0;
        @(negedge clk);
        chk("l1_ack", {d1_m0_ack, d1_m0_read_data}, {1'b1, 32'hCAFE_F00D});
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("l1_after", {d1_m0_ack, d1_busy, d1_m0_read_data},
            {1'b0, 1'b0, 32'hCAFE_F00D});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
